bus_controller: RTL

//  Two-core memory bus controller between the per-core cache blocks and the single-ported RAM.

---
 rtl/bus_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_controller.sv
// ---------------------------------------------------------------------------
// bus_controller
//
// Two-core memory bus controller sitting between the per-core cache blocks
// and a single-ported RAM. It arbitrates I-cache and D-cache requests of both
// cores onto the RAM, sequences MSI snoops for D-cache misses and
// invalidate-upgrades, and routes cache-to-cache (C2C) transfers when the
// snooped core holds the block Modified. It stores no data: the only state is
// the current transaction, its grantee and the round-robin "last granted" bit.
//
// Parameters
//   CPUS      number of cores; only 2 is supported (snoop target is ~grantee)
//   RR_RESET  "last granted" core after reset (0: core 1 wins the first tie)
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN/iaddr -> iwait/iload per-core instruction fetch channel
//   dREN/dWEN/daddr/dstore    per-core data channel request side
//   dwait/dload               per-core data channel response side
//   cctrans/ccwrite           per-core coherence request / snoop response
//   ccwait/ccinv/ccsnoopaddr  per-core snoop command outputs
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  single RAM port
// ---------------------------------------------------------------------------
module bus_controller #(
  parameter int   CPUS     = 2,
  parameter logic RR_RESET = 1'b0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  // instruction channel
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  // data channel
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  // coherence
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  // RAM port
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  // RAM states: FREE=0, BUSY=1, ACCESS=2, ERROR=3. Only ACCESS completes a
  // word; every other state simply keeps the current request on the bus.
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    SNOOP,
    LOAD,
    C2C,
    INV,
    IFETCH
  } state_t;

  state_t          state;
  logic            g;       // grantee of the current transaction
  logic            ng;      // the other core: snoop target / C2C supplier
  logic            last;    // core granted most recently (round robin)
  logic            acc;

  // arbitration result, only consumed while IDLE
  logic [CPUS-1:0] req;
  state_t          cls;
  logic            pick;

  assign ng  = ~g;
  assign acc = (ramstate == RAM_ACCESS);

  // -------------------------------------------------------------------------
  // Arbiter: writebacks beat coherence requests beat instruction fetches.
  // Inside a class a tie goes to the core that was not served last.
  // -------------------------------------------------------------------------
  always_comb begin
    req = '0;
    cls = IDLE;
    if (|dWEN) begin
      req = dWEN;
      cls = WB;
    end else if (|cctrans) begin
      req = cctrans;
      cls = SNOOP;
    end else if (|iREN) begin
      req = iREN;
      cls = IFETCH;
    end
    pick = (&req) ? ~last : req[1];
  end

  // -------------------------------------------------------------------------
  // Transaction sequencer. "last" is only updated when a transaction
  // finishes, so an aborted (reset) transaction never skews the rotation.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      g     <= 1'b0;
      last  <= RR_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (cls != IDLE) begin
            g <= pick;
            // a coherence request without a read is an invalidate-upgrade
            state <= (cls == SNOOP && !dREN[pick]) ? INV : cls;
          end
        end
        WB: begin
          // multi-word block writeback: stay until the core drops dWEN
          if (!dWEN[g]) begin
            state <= IDLE;
            last  <= g;
          end
        end
        SNOOP: begin
          // the snooped core answers within the snoop cycle
          state <= (cctrans[ng] && ccwrite[ng]) ? C2C : LOAD;
        end
        LOAD: begin
          if (!dREN[g]) begin
            state <= IDLE;
            last  <= g;
          end
        end
        C2C: begin
          // the supplier's writeback length decides the transfer length
          if (!dWEN[ng]) begin
            state <= IDLE;
            last  <= g;
          end
        end
        INV: begin
          state <= IDLE;
          last  <= g;
        end
        IFETCH: begin
          if (acc) begin
            state <= IDLE;
            last  <= g;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Everything the current state does not drive sits at its
  // reset value, so IDLE (and reset) presents a quiet bus. Waits react to
  // ramstate in the same cycle so the cache sees the word the RAM delivers.
  // -------------------------------------------------------------------------
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = {CPUS{ramload}};
    dload       = {CPUS{ramload}};

    unique case (state)
      IDLE: begin
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[g];
        dwait[g] = ~acc;
      end
      SNOOP: begin
        ccwait[ng]      = 1'b1;
        ccsnoopaddr[ng] = daddr[g];
        // requester intends to write: the snooper must drop its copy
        ccinv[ng]       = ccwrite[g];
      end
      LOAD: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[g];
        dwait[g]   = ~acc;
        ccwait[ng] = 1'b1;
      end
      C2C: begin
        // supplier's writeback goes to RAM and is forwarded to the requester
        ramWEN     = 1'b1;
        ramaddr    = daddr[ng];
        ramstore   = dstore[ng];
        dload[g]   = dstore[ng];
        dwait[g]   = ~acc;
        dwait[ng]  = ~acc;
        ccwait[ng] = 1'b1;
      end
      INV: begin
        ccwait[ng]      = 1'b1;
        ccinv[ng]       = 1'b1;
        ccsnoopaddr[ng] = daddr[g];
        dwait[g]        = 1'b0;
      end
      IFETCH: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr[g];
        iwait[g] = ~acc;
      end
      default: begin
      end
    endcase
  end

endmodule
